// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - generic FETCH/EXEC instruction step sequencer
// Steps each instruction through a 3-cycle fetch and a decoder-sized exec phase; state moves on the falling clock edge.
module exec_sequencer #(
  parameter int PC_W     = 8,
  parameter int STEP_W   = 3,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              op_valid_i,
  input  logic              op_halt_i,
  input  logic [STEP_W-1:0] op_len_i,
  input  logic              step_mem_i,
  input  logic              mem_ready_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              brk_en_i,
  input  logic [PC_W-1:0]   brk_addr_i,
  output logic [3:0]        fsm_state_o,
  output logic [STEP_W-1:0] exec_step_o,
  output logic              mem_req_o,
  output logic              instr_done_o,
  output logic              brk_hit_o,
  output logic              end_sq_o,
  output logic [1:0]        fault_o,
  output logic              pause_cc_o,
  output logic [CNT_W-1:0]  cycles_o,
  output logic [CNT_W-1:0]  instrs_o
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_F0    = 4'd1;
  localparam logic [3:0] S_F1    = 4'd2;
  localparam logic [3:0] S_F2    = 4'd3;
  localparam logic [3:0] S_EXEC  = 4'd4;
  localparam logic [3:0] S_PAUSE = 4'd5;
  localparam logic [3:0] S_HALT  = 4'd6;
  localparam logic [3:0] S_FAULT = 4'd7;

  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  // The stall that would be wait number MAX_WAIT is the one that trips the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [3:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_q, last_d;
  logic [7:0]        wait_q, wait_d;
  logic              brk_hit_q, brk_hit_d;
  logic [1:0]        fault_q, fault_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  instrs_q, instrs_d;

  logic active;
  logic in_exec;
  logic exec_adv;
  logic exec_last;
  logic wait_expired;
  logic brk_match;

  assign in_exec      = (state_q == S_EXEC);
  assign active       = (state_q == S_F0) || (state_q == S_F1) ||
                        (state_q == S_F2) || in_exec;
  assign exec_adv     = !step_mem_i || mem_ready_i;
  assign exec_last    = (step_q == last_q);
  assign wait_expired = (wait_q == WAIT_LAST);
  assign brk_match    = brk_en_i && (pc_i == brk_addr_i);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_d    = last_q;
    wait_d    = wait_q;
    brk_hit_d = brk_hit_q;
    fault_d   = fault_q;
    cycles_d  = cycles_q;
    instrs_d  = instrs_q;

    case (state_q)
      S_RESET: begin
        if (run_i || step_i) begin
          state_d = S_F0;
        end
      end
      S_F0: begin
        state_d = S_F1;
        wait_d  = '0;
      end
      S_F1: begin
        if (mem_ready_i) begin
          state_d = S_F2;
          wait_d  = '0;
        end else if (wait_expired) begin
          state_d = S_FAULT;
          fault_d = F_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_F2: begin
        wait_d = '0;
        step_d = '0;
        if (!op_valid_i) begin
          state_d = S_FAULT;
          fault_d = F_ILLEGAL;
        end else if (op_halt_i) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
          // A zero length from the decoder still runs one exec step.
          last_d  = (op_len_i == '0) ? '0 : op_len_i - STEP_W'(1);
        end
      end
      S_EXEC: begin
        if (exec_adv) begin
          wait_d = '0;
          if (exec_last) begin
            step_d   = '0;
            instrs_d = instrs_q + CNT_W'(1);
            if (brk_match) begin
              state_d   = S_PAUSE;
              brk_hit_d = 1'b1;
            end else if (!run_i) begin
              state_d = S_PAUSE;
            end else begin
              state_d = S_F0;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else if (wait_expired) begin
          state_d = S_FAULT;
          fault_d = F_TIMEOUT;
          step_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_PAUSE: begin
        // A step pulse always resumes; run alone cannot leave a breakpoint pause.
        if (step_i) begin
          state_d   = S_F0;
          brk_hit_d = 1'b0;
        end else if (run_i && !brk_hit_q) begin
          state_d = S_F0;
        end
      end
      S_HALT, S_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    if (active && (cycles_q != '1)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_RESET;
      step_q    <= '0;
      last_q    <= '0;
      wait_q    <= '0;
      brk_hit_q <= 1'b0;
      fault_q   <= 2'b00;
      cycles_q  <= '0;
      instrs_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      brk_hit_q <= brk_hit_d;
      fault_q   <= fault_d;
      cycles_q  <= cycles_d;
      instrs_q  <= instrs_d;
    end
  end

  assign fsm_state_o  = state_q;
  assign exec_step_o  = in_exec ? step_q : '0;
  assign mem_req_o    = (state_q == S_F0) || (state_q == S_F1) || (in_exec && step_mem_i);
  assign instr_done_o = in_exec && exec_adv && exec_last;
  assign brk_hit_o    = brk_hit_q;
  assign end_sq_o     = (state_q == S_HALT) || (state_q == S_FAULT);
  assign fault_o      = fault_q;
  assign pause_cc_o   = !active;
  assign cycles_o     = cycles_q;
  assign instrs_o     = instrs_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard bench for exec_sequencer
// Expected per-cycle observations are queued with the stimulus to apply after each sample.
module tb_exec_sequencer;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_F0    = 4'd1;
  localparam logic [3:0] S_F1    = 4'd2;
  localparam logic [3:0] S_F2    = 4'd3;
  localparam logic [3:0] S_EXEC  = 4'd4;
  localparam logic [3:0] S_PAUSE = 4'd5;
  localparam logic [3:0] S_HALT  = 4'd6;
  localparam logic [3:0] S_FAULT = 4'd7;

  logic       clock   = 1'b1;
  logic       reset_n = 1'b1;
  logic       run, step, op_valid, op_halt, step_mem, mem_ready, brk_en;
  logic [2:0] op_len;
  logic [7:0] pc, brk_addr;
  logic [3:0] fsm_state;
  logic [2:0] exec_step;
  logic       mem_req, instr_done, brk_hit, end_sq, pause_cc;
  logic [1:0] fault;
  logic [7:0] cycles, instrs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] st;
    logic [2:0] sp;
    logic       dn;
    logic       rq;
    logic       bh;
    logic       pcc;
    logic       es;
    logic       r;
    logic       s;
    logic       m;
    logic [7:0] pcv;
  } exp_t;

  exp_t exp_q[$];

  exec_sequencer #(.PC_W(8), .STEP_W(3), .MAX_WAIT(15), .CNT_W(8)) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .run_i        (run),
    .step_i       (step),
    .op_valid_i   (op_valid),
    .op_halt_i    (op_halt),
    .op_len_i     (op_len),
    .step_mem_i   (step_mem),
    .mem_ready_i  (mem_ready),
    .pc_i         (pc),
    .brk_en_i     (brk_en),
    .brk_addr_i   (brk_addr),
    .fsm_state_o  (fsm_state),
    .exec_step_o  (exec_step),
    .mem_req_o    (mem_req),
    .instr_done_o (instr_done),
    .brk_hit_o    (brk_hit),
    .end_sq_o     (end_sq),
    .fault_o      (fault),
    .pause_cc_o   (pause_cc),
    .cycles_o     (cycles),
    .instrs_o     (instrs)
  );

  always #5 clock = ~clock;

  // Queue one expected observation; r/s/m/pcv are driven right after it is sampled.
  function automatic void push(logic [3:0] st, logic [2:0] sp, logic dn, logic bh,
                               logic r, logic s, logic m, logic [7:0] pcv);
    exp_t e;
    e.st  = st;
    e.sp  = sp;
    e.dn  = dn;
    e.bh  = bh;
    e.rq  = (st == S_F0) || (st == S_F1) || ((st == S_EXEC) && step_mem);
    e.pcc = !((st >= S_F0) && (st <= S_EXEC));
    e.es  = (st == S_HALT) || (st == S_FAULT);
    e.r   = r;
    e.s   = s;
    e.m   = m;
    e.pcv = pcv;
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    run       = 1'b0;
    step      = 1'b0;
    op_valid  = 1'b1;
    op_halt   = 1'b0;
    op_len    = 3'd3;
    step_mem  = 1'b0;
    mem_ready = 1'b1;
    pc        = 8'h00;
    brk_en    = 1'b0;
    brk_addr  = 8'h00;
    exp_q.delete();
    repeat (2) @(posedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int idx = 0;
    do_reset();
    #1;
    n_cmp++;
    if ({fsm_state, exec_step, mem_req, instr_done, end_sq, pause_cc, brk_hit, fault} !==
        {S_RESET, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_outputs: got st=%0d step=%0d req=%b done=%b end=%b pcc=%b brk=%b fault=%b, want 0 0 0 0 0 1 0 00",
               fsm_state, exec_step, mem_req, instr_done, end_sq, pause_cc, brk_hit, fault);
    end
    n_cmp++;
    if (cycles !== 8'd0 || instrs !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_counters: got cycles=%0d instrs=%0d, want 0 0", cycles, instrs);
    end
    @(posedge clock);
    n_cmp++;
    if (fsm_state !== S_RESET) begin
      n_bad++;
      $display("FAIL reset_idle: got st=%0d, want %0d", fsm_state, S_RESET);
    end
    run = 1'b1;
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL reset_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (cycles !== 8'd5 || instrs !== 8'd0) begin
      n_bad++;
      $display("FAIL pre_abort_counters: got cycles=%0d instrs=%0d, want 5 0", cycles, instrs);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({fsm_state, exec_step, pause_cc, cycles, instrs} !== {S_RESET, 3'd0, 1'b1, 8'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL async_abort: got st=%0d step=%0d pcc=%b cycles=%0d instrs=%0d, want 0 0 1 0 0",
               fsm_state, exec_step, pause_cc, cycles, instrs);
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      push(S_EXEC, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      push(S_EXEC, 3'd2, 1'b1, 1'b0, (k == 0), 1'b0, 1'b1, 8'h00);
    end
    for (int k = 0; k < 4; k++) push(S_PAUSE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL free_run_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (cycles !== 8'd12 || instrs !== 8'd2) begin
      n_bad++;
      $display("FAIL free_run_counters: got cycles=%0d instrs=%0d, want 12 2", cycles, instrs);
    end
  endtask

  task automatic test_bus_timeout();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    mem_ready = 1'b0;
    push(S_F0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 15; k++) push(S_F1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL timeout_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (fault !== 2'b10) begin
      n_bad++;
      $display("FAIL timeout_fault: got fault=%b, want 10", fault);
    end
  endtask

  task automatic test_ready_at_limit();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    mem_ready = 1'b0;
    push(S_F0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 14; k++) push(S_F1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL ready_limit_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (fault !== 2'b00 || instrs !== 8'd1) begin
      n_bad++;
      $display("FAIL ready_limit_status: got fault=%b instrs=%0d, want 00 1", fault, instrs);
    end
  endtask

  task automatic test_exec_mem();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    op_len = 3'd2;
    step_mem = 1'b1;
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 15; k++) push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL exec_mem_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (fault !== 2'b10 || instrs !== 8'd1) begin
      n_bad++;
      $display("FAIL exec_timeout_status: got fault=%b instrs=%0d, want 10 1", fault, instrs);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    op_valid = 1'b0;
    op_halt = 1'b1;
    push(S_F0,    3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F1,    3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F2,    3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    push(S_FAULT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL illegal_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (fault !== 2'b01 || cycles !== 8'd3) begin
      n_bad++;
      $display("FAIL illegal_status: got fault=%b cycles=%0d, want 01 3", fault, cycles);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    op_halt = 1'b1;
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_HALT, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    push(S_HALT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    push(S_HALT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL halt_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (fault !== 2'b00 || instrs !== 8'd0) begin
      n_bad++;
      $display("FAIL halt_status: got fault=%b instrs=%0d, want 00 0", fault, instrs);
    end
  endtask

  task automatic test_breakpoint();
    exp_t e;
    int idx = 0;
    do_reset();
    run = 1'b1;
    op_len = 3'd0;
    brk_en = 1'b1;
    brk_addr = 8'h10;
    pc = 8'h10;
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    push(S_EXEC, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    push(S_PAUSE, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
    push(S_PAUSE, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
    push(S_PAUSE, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11);
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    push(S_EXEC, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL brk_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (instrs !== 8'd2) begin
      n_bad++;
      $display("FAIL brk_instrs: got instrs=%0d, want 2", instrs);
    end
  endtask

  task automatic test_single_step();
    exp_t e;
    int idx = 0;
    int dones = 0;
    do_reset();
    step = 1'b1;
    push(S_F0,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    push(S_F1,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    push(S_F2,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    push(S_EXEC, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 5; k++) push(S_PAUSE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(posedge clock);
      n_cmp++;
      if ({fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq} !== {e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es}) begin
        n_bad++;
        $display("FAIL single_step_trace[%0d]: got st=%0d step=%0d done=%b req=%b brk=%b pcc=%b end=%b, want %0d %0d %b %b %b %b %b",
                 idx, fsm_state, exec_step, instr_done, mem_req, brk_hit, pause_cc, end_sq, e.st, e.sp, e.dn, e.rq, e.bh, e.pcc, e.es);
      end
      run = e.r; step = e.s; mem_ready = e.m; pc = e.pcv;
      idx++;
    end
    n_cmp++;
    if (cycles !== 8'd6 || instrs !== 8'd1) begin
      n_bad++;
      $display("FAIL single_step_counters: got cycles=%0d instrs=%0d, want 6 1", cycles, instrs);
    end
    run = 1'b1;
    op_len = 3'd1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clock);
      if (instr_done === 1'b1) dones++;
    end
    n_cmp++;
    if (cycles !== 8'hFF) begin
      n_bad++;
      $display("FAIL cycles_saturate: got cycles=%0d, want 255", cycles);
    end
    run = 1'b0;
    for (int k = 0; k < 10 && fsm_state !== S_PAUSE; k++) begin
      @(posedge clock);
      if (instr_done === 1'b1) dones++;
    end
    n_cmp++;
    if (fsm_state !== S_PAUSE || instrs !== 8'(1 + dones) || cycles !== 8'hFF) begin
      n_bad++;
      $display("FAIL saturate_park: got st=%0d instrs=%0d cycles=%0d, want %0d %0d 255",
               fsm_state, instrs, cycles, S_PAUSE, 8'(1 + dones));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared, want completion", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_free_run();
    test_bus_timeout();
    test_ready_at_limit();
    test_exec_mem();
    test_illegal();
    test_halt();
    test_breakpoint();
    test_single_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
